mcash_chn_rtn_rob: RTL and testbench
====================================

Name: mcash_chn_rtn_rob

Overview:
Per-channel return reorder buffer. It sits between the cross-bar bank response paths and the channel return port (mcash_chN_rtn_valid_o). Each accepted channel read request gets a tag at kickoff. The four banks return data out of order, tagged. The block re-emits the data to the channel strictly in request order, one beat per cycle, with no backpressure. One instance is built per channel (three total).

Parameters:
DEPTH, 8, number of ROB entries; power of two.
TAG_W, 3, tag width; equals log2(DEPTH).
DATA_W, 32, return data width.
BANK_NUM, 4, number of bank response ports.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
alloc_valid_i  input  1  channel request kickoff (req_valid & req_allowIn)
alloc_ready_o  output  1  a free entry exists; gates the channel's req_allowIn
alloc_tag_o  output  TAG_W  tag assigned to the kickoff in the current cycle (equals tail index)
bank_resp_valid_i  input  BANK_NUM  per-bank response valid
bank_resp_tag_i  input  BANK_NUM*TAG_W  per-bank response tag; bank b occupies [b*TAG_W +: TAG_W]
bank_resp_data_i  input  BANK_NUM*DATA_W  per-bank response data; same slicing
rtn_valid_o  output  1  in-order return beat
rtn_data_o  output  DATA_W  return data
outstanding_cnt_o  output  TAG_W+1  allocated-but-not-retired entry count
err_o  output  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high. All state updates on the posedge of clk_i.
- Reset values:
  - Registered outputs: rtn_valid_o=0, rtn_data_o=0, outstanding_cnt_o=0, err_o=0.
  - Combinational outputs after reset: alloc_ready_o=1, alloc_tag_o=0.
  - State: head, tail and their wrap bits cleared; all per-entry alloc/done bits cleared.
- Reset mid-operation: in-flight entries are discarded, with no return beats.
- Pointers:
  - head and tail are TAG_W+1 bits (the MSB is the wrap bit).
  - Full is indices equal with wrap bits different. Empty is head == tail.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
- Allocate:
  - alloc_ready_o = ~full, computed from registered state only. There is no bypass from a same-cycle retire, so when full, alloc_ready_o stays 0 even if an entry retires that cycle.
  - When alloc_valid_i & alloc_ready_o: entry[tail].alloc<=1, done<=0; tail++.
  - alloc_valid_i while full is an error: err_o<=1 and the request is ignored.
- Response capture:
  - For each bank b with valid set, if entry[tag].alloc & ~done: data<=bank data, done<=1.
  - Multiple banks may respond in the same cycle with distinct tags; all are captured.
- Response errors (each sets err_o; the offending beat is dropped):
  - Response to an unallocated tag.
  - Response to an already-done tag.
  - Two banks using the same tag in one cycle: the lowest-numbered bank wins and the others are dropped.
- Retire:
  - When entry[head].alloc & done (registered): rtn_valid_o<=1, rtn_data_o<=entry data, clear alloc/done, head++.
  - Otherwise rtn_valid_o<=0; rtn_data_o holds its value.
  - At most one retire per cycle.
- Latency: a response in cycle N to the head entry produces rtn_valid_o in cycle N+2. This is the minimum; there is no response-to-return bypass.
- Count:
  - outstanding_cnt_o is +1 on alloc, -1 on retire, unchanged when both or neither happen.
  - The decrement uses the retire event, not rtn_valid_o.
  - Range is 0..DEPTH and it never wraps.
- err_o is sticky until rst_i.

Decomposition:
- Package mcash_rob_pkg holds:
  - BANK_NUM and the default DEPTH, DATA_W and TAG_W constants.
  - A typedef rob_entry_t {alloc, done, data}.
  - A function for per-bank tag/data slicing.
- One sub-module is natural: mcash_rob_resp_arb, the combinational per-tag bank select with lowest-bank priority and duplicate-tag detection. All other logic stays flat.

Test Plan:
- In-order single beat: alloc tag 0; bank2 returns tag 0 with 0xA5A5_0001 in cycle 10 -> rtn_valid_o=1 with rtn_data_o=0xA5A5_0001 in cycle 12; outstanding_cnt_o goes 1 -> 0.
- Out-of-order: alloc tags 0..3; banks return tags 3,2,1,0 in cycles 10..13 with data 0x3,0x2,0x1,0x0 -> rtn_valid_o in cycles 15..18 with data 0x0,0x1,0x2,0x3.
- Same-cycle multi-bank: alloc tags 0..3; all four banks return them in cycle 10 -> four consecutive rtn_valid_o beats in cycles 12..15, in tag order.
- Full/wrap: alloc 8 without responses -> alloc_ready_o=0 and outstanding_cnt_o=8. Retire tag 0 -> alloc_ready_o=1 the following cycle; the next alloc gets alloc_tag_o=0 with the wrap bit toggled; 20 continuous alloc/resp cycles stay in order.
- Errors: a response to an unallocated tag 5, and bank0/bank1 sharing tag 1 -> err_o=1 stays high; tag 1 takes bank0's data; no spurious rtn_valid_o.
- Reset mid-flight: 3 entries outstanding, rst_i high for 1 cycle -> all outputs return to reset values; late bank responses set err_o; no return beats.

Source files
------------

// File: rtl/mcash_rob_pkg.sv
// Shared constants, the ROB entry record and bank-bus slicing helpers for the
// per-channel return reorder buffer.
package mcash_rob_pkg;

  localparam int BANK_NUM   = 4;
  localparam int DEPTH_DEF  = 8;
  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic                  alloc;
    logic                  done;
    logic [DATA_W_DEF-1:0] data;
  } rob_entry_t;

  function automatic logic [TAG_W_DEF-1:0] slice_tag(
    input logic [BANK_NUM*TAG_W_DEF-1:0] bus,
    input int unsigned                   bank
  );
    return bus[bank*TAG_W_DEF +: TAG_W_DEF];
  endfunction

  function automatic logic [DATA_W_DEF-1:0] slice_data(
    input logic [BANK_NUM*DATA_W_DEF-1:0] bus,
    input int unsigned                    bank
  );
    return bus[bank*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/mcash_chn_rtn_rob_if.sv
// Channel-side allocate port, bank response ports and in-order return port.
// alloc_valid_i/alloc_ready_o: a kickoff is taken only in a cycle where both are
// high; bank responses and the return beat are valid-only with no backpressure.
interface mcash_chn_rtn_rob_if #(
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32,
  parameter int BANK_NUM = 4
);

  logic                       alloc_valid_i;
  logic                       alloc_ready_o;
  logic [TAG_W-1:0]           alloc_tag_o;
  logic [BANK_NUM-1:0]        bank_resp_valid_i;
  logic [BANK_NUM*TAG_W-1:0]  bank_resp_tag_i;
  logic [BANK_NUM*DATA_W-1:0] bank_resp_data_i;
  logic                       rtn_valid_o;
  logic [DATA_W-1:0]          rtn_data_o;
  logic [TAG_W:0]             outstanding_cnt_o;
  logic                       err_o;

  modport slave (
    input  alloc_valid_i, bank_resp_valid_i, bank_resp_tag_i, bank_resp_data_i,
    output alloc_ready_o, alloc_tag_o, rtn_valid_o, rtn_data_o,
           outstanding_cnt_o, err_o
  );

  modport master (
    output alloc_valid_i, bank_resp_valid_i, bank_resp_tag_i, bank_resp_data_i,
    input  alloc_ready_o, alloc_tag_o, rtn_valid_o, rtn_data_o,
           outstanding_cnt_o, err_o
  );

endinterface

// File: rtl/mcash_rob_resp_arb.sv
// Per-cycle bank response select: when several banks carry the same tag the
// lowest-numbered bank keeps it and the collision is flagged.
module mcash_rob_resp_arb #(
  parameter int BANK_NUM = 4,
  parameter int TAG_W    = 3
) (
  input  logic [BANK_NUM-1:0]       valid_i,
  input  logic [BANK_NUM*TAG_W-1:0] tag_i,
  output logic [BANK_NUM-1:0]       grant_o,
  output logic                      dup_err_o
);

  always_comb begin
    grant_o   = valid_i;
    dup_err_o = 1'b0;
    for (int b = 1; b < BANK_NUM; b++) begin
      for (int j = 0; j < b; j++) begin
        if (valid_i[j] && valid_i[b] &&
            (tag_i[j*TAG_W +: TAG_W] == tag_i[b*TAG_W +: TAG_W])) begin
          grant_o[b] = 1'b0;
          dup_err_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mcash_chn_rtn_rob.sv
// Per-channel return reorder buffer: tags kickoffs in order, captures tagged
// bank data out of order and replays it one beat per cycle in request order.
module mcash_chn_rtn_rob #(
  parameter int DEPTH    = mcash_rob_pkg::DEPTH_DEF,
  parameter int TAG_W    = mcash_rob_pkg::TAG_W_DEF,
  parameter int DATA_W   = mcash_rob_pkg::DATA_W_DEF,
  parameter int BANK_NUM = mcash_rob_pkg::BANK_NUM
) (
  input logic               clk_i,
  input logic               rst_i,
  mcash_chn_rtn_rob_if.slave bus
);

  import mcash_rob_pkg::*;

  typedef logic [TAG_W:0] ptr_t;

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;
  ptr_t              cnt_q, cnt_d;
  logic              rtn_valid_q, rtn_valid_d;
  logic [DATA_W-1:0] rtn_data_q, rtn_data_d;
  logic              err_q, err_d;

  logic [TAG_W-1:0]    head_idx, tail_idx, resp_tag;
  logic                full, alloc_fire, alloc_err, retire, resp_err, dup_err;
  logic [BANK_NUM-1:0] grant;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Full comes from registered pointers only; a same-cycle retire never reopens it.
  assign full       = (head_q[TAG_W] != tail_q[TAG_W]) && (head_idx == tail_idx);
  assign alloc_fire = bus.alloc_valid_i & ~full;
  assign alloc_err  = bus.alloc_valid_i & full;
  assign retire     = entries_q[head_idx].alloc & entries_q[head_idx].done;

  assign bus.alloc_ready_o     = ~full;
  assign bus.alloc_tag_o       = tail_idx;
  assign bus.rtn_valid_o       = rtn_valid_q;
  assign bus.rtn_data_o        = rtn_data_q;
  assign bus.outstanding_cnt_o = cnt_q;
  assign bus.err_o             = err_q;

  mcash_rob_resp_arb #(
    .BANK_NUM (BANK_NUM),
    .TAG_W    (TAG_W)
  ) u_resp_arb (
    .valid_i   (bus.bank_resp_valid_i),
    .tag_i     (bus.bank_resp_tag_i),
    .grant_o   (grant),
    .dup_err_o (dup_err)
  );

  always_comb begin
    entries_d = entries_q;
    resp_err  = 1'b0;
    resp_tag  = '0;
    if (alloc_fire) begin
      entries_d[tail_idx].alloc = 1'b1;
      entries_d[tail_idx].done  = 1'b0;
    end
    // Granted tags are distinct, so each bank touches a different entry.
    for (int b = 0; b < BANK_NUM; b++) begin
      if (grant[b]) begin
        resp_tag = slice_tag(bus.bank_resp_tag_i, b);
        if (entries_q[resp_tag].alloc && !entries_q[resp_tag].done) begin
          entries_d[resp_tag].done = 1'b1;
          entries_d[resp_tag].data = slice_data(bus.bank_resp_data_i, b);
        end else begin
          resp_err = 1'b1;
        end
      end
    end
    if (retire) begin
      entries_d[head_idx].alloc = 1'b0;
      entries_d[head_idx].done  = 1'b0;
    end
  end

  always_comb begin
    head_d      = head_q + ptr_t'(retire);
    tail_d      = tail_q + ptr_t'(alloc_fire);
    rtn_valid_d = retire;
    rtn_data_d  = retire ? entries_q[head_idx].data : rtn_data_q;
    err_d       = err_q | alloc_err | resp_err | dup_err;
    cnt_d       = cnt_q;
    case ({alloc_fire, retire})
      2'b10:   cnt_d = cnt_q + ptr_t'(1);
      2'b01:   cnt_d = cnt_q - ptr_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      rtn_valid_q <= 1'b0;
      rtn_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      rtn_valid_q <= rtn_valid_d;
      rtn_data_q  <= rtn_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mcash_chn_rtn_rob.sv
// Bench for the channel return reorder buffer: directed scenarios plus random
// traffic, checked every cycle against an in-order queue model of the buffer.
module tb_mcash_chn_rtn_rob;

  localparam int DEPTH    = 8;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 32;
  localparam int BANK_NUM = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mcash_chn_rtn_rob_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .BANK_NUM(BANK_NUM)) bus ();

  mcash_chn_rtn_rob #(
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W),
    .BANK_NUM (BANK_NUM)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Reference model: outstanding tags in request order plus captured data per tag.
  int                m_order[$];
  bit                m_has [DEPTH];
  logic [DATA_W-1:0] m_dat [DEPTH];
  int                m_next;
  bit                m_err;
  bit                m_rv;
  logic [DATA_W-1:0] m_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_outstanding(input int t);
    foreach (m_order[i]) if (m_order[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_order.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_has[i] = 1'b0;
      m_dat[i] = '0;
    end
    m_next = 0;
    m_err  = 1'b0;
    m_rv   = 1'b0;
    m_rd   = '0;
  endtask

  task automatic model_edge();
    bit seen [DEPTH];
    bit full_pre;
    int t;
    if (rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
    full_pre = (m_order.size() == DEPTH);
    // Oldest request leaves once its data was captured on an earlier edge.
    if (m_order.size() > 0 && m_has[m_order[0]]) begin
      t        = m_order.pop_front();
      m_rv     = 1'b1;
      m_rd     = m_dat[t];
      m_has[t] = 1'b0;
      exp_q.push_back(m_rd);
    end else begin
      m_rv = 1'b0;
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      if (bus.bank_resp_valid_i[b]) begin
        t = int'(bus.bank_resp_tag_i[b*TAG_W +: TAG_W]);
        if (seen[t]) begin
          m_err = 1'b1;
        end else begin
          seen[t] = 1'b1;
          if (!is_outstanding(t) || m_has[t]) begin
            m_err = 1'b1;
          end else begin
            m_has[t] = 1'b1;
            m_dat[t] = bus.bank_resp_data_i[b*DATA_W +: DATA_W];
          end
        end
      end
    end
    if (bus.alloc_valid_i) begin
      if (full_pre) begin
        m_err = 1'b1;
      end else begin
        m_order.push_back(m_next);
        m_has[m_next] = 1'b0;
        m_next = (m_next + 1) % DEPTH;
      end
    end
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] exp;
    check_eq("alloc_ready", 64'(bus.alloc_ready_o), 64'(m_order.size() < DEPTH));
    check_eq("alloc_tag", 64'(bus.alloc_tag_o), 64'(m_next));
    check_eq("rtn_valid", 64'(bus.rtn_valid_o), 64'(m_rv));
    if (m_rv && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_eq("rtn_order", 64'(bus.rtn_data_o), 64'(exp));
    end
    check_eq("rtn_data", 64'(bus.rtn_data_o), 64'(m_rd));
    check_eq("outstanding", 64'(bus.outstanding_cnt_o), 64'(m_order.size()));
    check_eq("err", 64'(bus.err_o), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.alloc_valid_i     = 1'b0;
    bus.bank_resp_valid_i = '0;
    bus.bank_resp_tag_i   = '0;
    bus.bank_resp_data_i  = '0;
  endtask

  task automatic set_resp(input int b, input int tag, input logic [DATA_W-1:0] d);
    bus.bank_resp_valid_i[b]                = 1'b1;
    bus.bank_resp_tag_i[b*TAG_W +: TAG_W]   = TAG_W'(tag);
    bus.bank_resp_data_i[b*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      bus.alloc_valid_i = 1'b1;
      step();
    end
    idle();
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  task automatic random_cycle(input bit allow_err);
    int cand[$];
    int idx;
    idle();
    foreach (m_order[i]) if (!m_has[m_order[i]]) cand.push_back(m_order[i]);
    bus.alloc_valid_i = (allow_err || m_order.size() < DEPTH) && ($urandom_range(0, 3) != 0);
    for (int b = 0; b < BANK_NUM; b++) begin
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, cand.size() - 1);
        set_resp(b, cand[idx], $urandom);
        cand.delete(idx);
      end
    end
    if (allow_err && $urandom_range(0, 15) == 0)
      set_resp($urandom_range(0, BANK_NUM - 1), $urandom_range(0, DEPTH - 1), $urandom);
    step();
  endtask

  initial begin
    model_clear();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // In-order single beat through bank 2.
    alloc_n(1);
    drain(3);
    set_resp(2, 0, 32'hA5A5_0001);
    step();
    drain(4);

    // Out-of-order return of tags 3..0.
    do_reset();
    alloc_n(4);
    for (int i = 0; i < 4; i++) begin
      idle();
      set_resp(i % BANK_NUM, 3 - i, DATA_W'(3 - i));
      step();
    end
    drain(6);

    // All four banks answer in one cycle.
    do_reset();
    alloc_n(4);
    for (int b = 0; b < BANK_NUM; b++) set_resp(b, b, 32'hC0DE_0000 + DATA_W'(b));
    step();
    drain(6);

    // Fill to full, release the head, then wrap the pointers.
    do_reset();
    alloc_n(DEPTH);
    drain(2);
    set_resp(1, 0, 32'h0000_F00D);
    step();
    drain(3);
    alloc_n(1);
    for (int i = 0; i < 20; i++) random_cycle(1'b0);
    for (int i = 0; i < 60; i++) begin
      idle();
      for (int b = 0; b < BANK_NUM; b++)
        if (b < m_order.size() && !m_has[m_order[b]]) set_resp(b, m_order[b], $urandom);
      step();
    end

    // Protocol errors: unallocated tag, duplicate tag, alloc while full.
    do_reset();
    alloc_n(2);
    set_resp(0, 5, 32'hDEAD_0005);
    step();
    idle();
    set_resp(0, 1, 32'h1111_0000);
    set_resp(1, 1, 32'h2222_0000);
    step();
    drain(3);
    alloc_n(DEPTH);
    idle();
    set_resp(3, 0, 32'h0000_0A0A);
    step();
    drain(4);

    // Reset with three entries in flight, then late responses.
    do_reset();
    alloc_n(3);
    do_reset();
    for (int t = 0; t < 3; t++) begin
      idle();
      set_resp(t, t, $urandom);
      step();
    end
    drain(3);

    // Random legal traffic, then random traffic with injected errors.
    do_reset();
    for (int i = 0; i < 3000; i++) random_cycle(1'b0);
    drain(20);
    do_reset();
    for (int i = 0; i < 1500; i++) random_cycle(1'b1);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
